// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - icache request/response handshake between fetch_ctrl and the icache
interface fetch_ctrl_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_addr_ok;
  logic        icache_data_ok;

  modport master (
    output icache_req,
    output icache_addr,
    input  icache_addr_ok,
    input  icache_data_ok
  );

  modport slave (
    input  icache_req,
    input  icache_addr,
    output icache_addr_ok,
    output icache_data_ok
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - front-end fetch sequencer: next-PC arbitration, icache issue, stale-response drop
// Optional perf counters are enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int          MAX_OUT  = 2,
  parameter int          CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exc_redirect,
  input  logic [31:0]         epc,
  input  logic                mis_redirect,
  input  logic [31:0]         mis_target,
  input  logic                bpu_valid,
  input  logic [31:0]         bpu_target,
  input  logic [CREDIT_W-1:0] ibuf_credit,
  fetch_ctrl_if.master        ic,
  output logic                resp_valid,
  output logic [31:0]         resp_pc,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_dropped,
  output logic [31:0]         perf_redirects,
  output logic [31:0]         perf_stall_credit,
`endif
  output logic [31:0]         fetch_pc
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [1:0] MAX_O = 2'(MAX_OUT);

  state_t      state, state_next;
  logic [1:0]  outstanding, out_after_ret, out_next;
  logic [1:0]  drop_cnt, drop_base, drop_next;
  logic        pend_valid, pend_exc;
  logic [31:0] pend_target, pc_next, redirect_target;
  logic        redirect, accept, retire, drop_resp;
  logic [31:0] pc_fifo [4];
  logic [1:0]  wr_ptr, rd_ptr;

  function automatic logic can_issue(input logic [1:0] o, input logic [CREDIT_W-1:0] credit,
                                     input logic redir);
    return (o < MAX_O) && (credit > CREDIT_W'(o)) && !redir;
  endfunction

  function automatic logic [1:0] bump(input logic [1:0] p);
    return (p == MAX_O - 2'd1) ? 2'd0 : p + 2'd1;
  endfunction

  assign redirect        = exc_redirect | mis_redirect;
  assign redirect_target = exc_redirect ? epc : mis_target;
  assign accept          = (state == REQ) && ic.icache_addr_ok;
  assign retire          = ic.icache_data_ok && (outstanding != 2'd0);
  assign drop_resp       = retire && (drop_cnt != 2'd0);
  assign out_after_ret   = outstanding - {1'b0, retire};
  assign out_next        = out_after_ret + {1'b0, accept};
  assign drop_base       = drop_cnt - {1'b0, drop_resp};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (can_issue(outstanding, ibuf_credit, redirect)) state_next = REQ;
      REQ:  if (accept) state_next = can_issue(out_next, ibuf_credit, redirect) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ic.icache_req  = (state == REQ);
    ic.icache_addr = fetch_pc;
    resp_valid     = retire && (drop_cnt == 2'd0);
    resp_pc        = pc_fifo[rd_ptr];
  end

  // A redirect turns every in-flight request stale, plus one being accepted this cycle.
  always_comb begin
    drop_next = drop_base;
    if (redirect)                  drop_next = out_after_ret + {1'b0, accept};
    else if (accept && pend_valid) drop_next = drop_base + 2'd1;
  end

  // While a request is held in REQ its address must not move, so redirects wait in pend_*.
  always_comb begin
    pc_next = fetch_pc;
    if (redirect && (state == IDLE || accept)) pc_next = redirect_target;
    else if (accept) begin
      if (pend_valid)     pc_next = pend_target;
      else if (bpu_valid) pc_next = bpu_target;
      else                pc_next = fetch_pc + 32'd8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
      pend_valid  <= 1'b0;
      pend_exc    <= 1'b0;
      pend_target <= 32'd0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
    end else begin
      fetch_pc    <= pc_next;
      outstanding <= out_next;
      drop_cnt    <= drop_next;
      if (accept) wr_ptr <= bump(wr_ptr);
      if (retire) rd_ptr <= bump(rd_ptr);
      if (accept) begin
        pend_valid <= 1'b0;
      end else if (state == REQ && redirect && (exc_redirect || !(pend_valid && pend_exc))) begin
        pend_valid  <= 1'b1;
        pend_exc    <= exc_redirect;
        pend_target <= redirect_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pc_fifo[wr_ptr] <= fetch_pc;
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued       <= 32'd0;
      perf_dropped      <= 32'd0;
      perf_redirects    <= 32'd0;
      perf_stall_credit <= 32'd0;
    end else begin
      if (accept)    perf_issued    <= perf_issued + 32'd1;
      if (drop_resp) perf_dropped   <= perf_dropped + 32'd1;
      if (redirect)  perf_redirects <= perf_redirects + 32'd1;
      if (state == IDLE && outstanding < MAX_O && !redirect && ibuf_credit <= CREDIT_W'(outstanding))
        perf_stall_credit <= perf_stall_credit + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction-fetch requests from the PC to the instruction cache.
- Arbitrates next-PC sources: exception redirect, branch-mispredict redirect, BPU prediction, sequential +8.
- Tracks in-flight icache requests, discards responses made stale by a redirect, and throttles issue against ibuffer free space.
- Sits between the PC/BPU logic and the icache/ibuffer in the front end.

Parameters:
- RESET_PC, 32'hbfc00000, fetch address issued first after reset.
- MAX_OUT, 2, maximum outstanding icache requests (1..3).
- CREDIT_W, 4, width of the ibuffer free-slot count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- exc_redirect  in  1  exception flush; target is epc.
- epc  in  32  exception target.
- mis_redirect  in  1  mispredict flush; target is mis_target.
- mis_target  in  32  corrected PC: npc_actual if taken, ex_pc+8 if not, selected upstream.
- bpu_valid  in  1  prediction for the currently issued address.
- bpu_target  in  32  predicted fetch address.
- ibuf_credit  in  CREDIT_W  free 2-instruction slots in the ibuffer.
- icache_req  out  1  request valid.
- icache_addr  out  32  request address.
- icache_addr_ok  in  1  request accepted this cycle.
- icache_data_ok  in  1  response returned this cycle (in order).
- resp_valid  out  1  response forwarded to the ibuffer.
- resp_pc  out  32  PC of the forwarded response.
- fetch_pc  out  32  next address to be issued.

Behaviour:
- Reset values: fetch_pc=RESET_PC, icache_req=0, resp_valid=0, outstanding=0, drop_cnt=0, state=IDLE, pending redirect cleared.
- Redirect priority: exc_redirect > mis_redirect > bpu_valid > sequential.
- A redirect asserted in cycle N sets fetch_pc to its target at edge N+1.
- Sequential next address is fetch_pc+8, wrapping modulo 2^32.
- bpu_valid is honoured only in the cycle icache_addr_ok fires; fetch_pc then becomes bpu_target.
- States:
  - IDLE: icache_req=0. Move to REQ when outstanding<MAX_OUT, ibuf_credit>outstanding, and no redirect this cycle.
  - REQ: icache_req=1 and icache_addr=fetch_pc, held stable until icache_addr_ok. On addr_ok: outstanding+1, fetch_pc advances, return to REQ if the issue conditions still hold, else IDLE.
- A redirect while in REQ without addr_ok does not change icache_addr. The target is latched in a pending register, with an exception overwriting a pending mispredict. When that request is accepted, it is counted as stale (drop_cnt+1), fetch_pc takes the pending target, and pending clears.
- A redirect in the same cycle as addr_ok: the accepted request is stale (drop_cnt+1) and fetch_pc takes the redirect target.
- Redirect in any state: drop_cnt += current outstanding, excluding same-cycle data_ok. Saturate at MAX_OUT.
- icache_data_ok:
  - outstanding-1.
  - If drop_cnt>0: drop_cnt-1 and resp_valid=0.
  - Otherwise resp_valid=1, with resp_pc taken from a MAX_OUT-deep in-order PC FIFO that is written on each addr_ok.
- resp_valid is combinational with data_ok and lasts one cycle.
- addr_ok and data_ok in the same cycle: outstanding is unchanged.
- ibuf_credit==0 or ibuf_credit<=outstanding: no new request. A request already in REQ stays until accepted; the address handshake is never withdrawn.
- Reset mid-operation: all state returns to reset values in the same edge. Late data_ok after reset is ignored, with outstanding held at 0.
- outstanding never exceeds MAX_OUT. data_ok with outstanding==0 is an upstream error and is ignored.

Optional Feature:
- FETCH_CTRL_PERF_EN defined:
  - Adds 32-bit output counters perf_issued, perf_dropped and perf_redirects, each incrementing per event and wrapping.
  - Cleared by rst.
  - Adds an output perf_stall_credit counting cycles blocked only by credit.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset release, addr_ok immediately each cycle, credit=8 -> icache_addr 0xbfc00000, 0xbfc00008, 0xbfc00010; resp_pc matches each on data_ok.
- BPU hit with bpu_valid=1, bpu_target=0xbfc00100 at accept of 0xbfc00008 -> next icache_addr 0xbfc00100.
- Two outstanding (0xbfc00000, 0xbfc00008), mis_redirect to 0x80001000 -> both data_ok give resp_valid=0; next request is 0x80001000 and its response has resp_valid=1.
- icache_addr=0xbfc00010 held in REQ without addr_ok, then exc_redirect epc=0xbfc00380 -> address stays 0xbfc00010 until addr_ok; its response is dropped; next request is 0xbfc00380.
- exc_redirect and mis_redirect in the same cycle -> fetch_pc=epc.
- credit throttling: ibuf_credit=1, outstanding=1 -> icache_req stays 0 until data_ok; credit=0 for 10 cycles -> no request.
- Reset asserted with outstanding=2 -> next cycle icache_req=0 and fetch_pc=0xbfc00000; subsequent data_ok gives resp_valid=0.
